// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/LSU memory arbiter: access sizes, response owners, lane masks.
// Response context captured on each grant and decoded one cycle later.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IF   = 2'b01,
        OWN_LS   = 2'b10
    } owner_e;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Round-robin pointer encoding: which requester wins the next contended cycle.
    localparam logic PTR_IF = 1'b0;
    localparam logic PTR_LS = 1'b1;

    typedef struct packed {
        owner_e      owner;
        logic        err;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  ofs;
        logic        is_store;
    } ctx_t;

    localparam ctx_t CTX_RST = '{OWN_NONE, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, LSU and memory-port signals; slave = arbiter side, master = requesters + memory.
// Requests handshake valid/ready; responses are single-cycle pulses with no back-pressure.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  if_req_valid;
    logic                  if_req_ready;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_rsp_valid;
    logic [31:0]           if_rsp_data;
    logic                  if_rsp_err;

    logic                  ls_req_valid;
    logic                  ls_req_ready;
    logic [ADDR_WIDTH-1:0] ls_addr;
    logic                  ls_we;
    logic [1:0]            ls_size;
    logic                  ls_unsigned;
    logic [31:0]           ls_wdata;
    logic                  ls_rsp_valid;
    logic [31:0]           ls_rsp_data;
    logic                  ls_rsp_err;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wr_en;
    logic [31:0]           mem_wr_data;
    logic [31:0]           mem_rd_data;
    logic [3:0]            mem_byte_en;

    modport slave (
        input  if_req_valid, if_addr,
        output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        input  ls_req_valid, ls_addr, ls_we, ls_size, ls_unsigned, ls_wdata,
        output ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_err,
        output mem_addr, mem_wr_en, mem_wr_data, mem_byte_en,
        input  mem_rd_data
    );

    modport master (
        output if_req_valid, if_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        output ls_req_valid, ls_addr, ls_we, ls_size, ls_unsigned, ls_wdata,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_err,
        input  mem_addr, mem_wr_en, mem_wr_data, mem_byte_en,
        output mem_rd_data
    );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: request-side enables/replication/misalign check, response-side extract+extend.
// Zero latency; no flow control of its own.
module mem_lane_align
    import mem_arb_pkg::*;
(
    input  logic [1:0]  req_size,
    input  logic [1:0]  req_ofs,
    input  logic [31:0] st_data,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_data,
    output logic        misalign,
    input  logic [1:0]  rsp_size,
    input  logic [1:0]  rsp_ofs,
    input  logic        rsp_uns,
    input  logic [31:0] rd_data,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    always_comb begin
        misalign = 1'b0;
        byte_en  = BE_NONE;
        wr_data  = st_data;
        case (req_size)
            SZ_B: begin
                byte_en = BE_BYTE << req_ofs;
                wr_data = {4{st_data[7:0]}};
            end
            SZ_H: begin
                misalign = req_ofs[0];
                byte_en  = BE_HALF << req_ofs;
                wr_data  = {2{st_data[15:0]}};
            end
            SZ_W: begin
                misalign = (req_ofs != 2'b00);
                byte_en  = BE_WORD;
            end
            default: misalign = 1'b1;
        endcase
        // A rejected access must never reach the memory lanes.
        if (misalign) begin
            byte_en = BE_NONE;
        end
    end

    always_comb begin
        ld_b = rd_data[{rsp_ofs, 3'b000} +: 8];
        ld_h = rd_data[{rsp_ofs[1], 4'b0000} +: 16];
        case (rsp_size)
            SZ_B:    ld_data = {{24{ld_b[7] & ~rsp_uns}}, ld_b};
            SZ_H:    ld_data = {{16{ld_h[15] & ~rsp_uns}}, ld_h};
            default: ld_data = rd_data;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch vs LSU onto one byte-enabled memory port; grant in cycle N, response in N+1, one grant/cycle.
// Loser's ready stays low until granted; MEM_ARB_RR_EN selects round-robin, else fixed LSU-first.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    logic                  ls_gnt;
    logic                  if_gnt;
    logic                  any_gnt;
    logic                  prefer_ls;
    logic [1:0]            req_size;
    logic [1:0]            req_ofs;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [3:0]            al_be;
    logic [31:0]           al_wd;
    logic                  al_err;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  if_vld;
    logic                  ls_vld;
    logic                  st_ok;
    ctx_t                  ctx_d;
    ctx_t                  ctx_q;

`ifdef MEM_ARB_RR_EN
    logic rr_d;
    logic rr_q;

    // The pointer always points away from whoever was just served.
    always_comb begin
        rr_d = rr_q;
        if (ls_gnt) begin
            rr_d = PTR_IF;
        end else if (if_gnt) begin
            rr_d = PTR_LS;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q <= PTR_IF;
        end else begin
            rr_q <= rr_d;
        end
    end

    assign prefer_ls = (rr_q == PTR_LS);
`else
    assign prefer_ls = 1'b1;
`endif

    assign ls_gnt  = rst_n & bus.ls_req_valid & (~bus.if_req_valid | prefer_ls);
    assign if_gnt  = rst_n & bus.if_req_valid & ~ls_gnt;
    assign any_gnt = ls_gnt | if_gnt;

    assign bus.ls_req_ready = ls_gnt;
    assign bus.if_req_ready = if_gnt;

    // Fetches are checked and laned as aligned word reads.
    assign req_size = if_gnt ? SZ_W : bus.ls_size;
    assign req_ofs  = if_gnt ? bus.if_addr[1:0] : bus.ls_addr[1:0];
    assign req_addr = if_gnt ? bus.if_addr : bus.ls_addr;

    mem_lane_align u_align (
        .req_size (req_size),
        .req_ofs  (req_ofs),
        .st_data  (bus.ls_wdata),
        .byte_en  (al_be),
        .wr_data  (al_wd),
        .misalign (al_err),
        .rsp_size (ctx_q.size),
        .rsp_ofs  (ctx_q.ofs),
        .rsp_uns  (ctx_q.uns),
        .rd_data  (bus.mem_rd_data),
        .ld_data  (ld_data)
    );

    assign st_ok           = ls_gnt & bus.ls_we & ~al_err;
    assign bus.mem_addr    = any_gnt ? {req_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign bus.mem_byte_en = any_gnt ? al_be : BE_NONE;
    assign bus.mem_wr_en   = st_ok;
    assign bus.mem_wr_data = st_ok ? al_wd : 32'h0;

    always_comb begin
        ctx_d          = CTX_RST;
        ctx_d.err      = any_gnt & al_err;
        ctx_d.size     = req_size;
        ctx_d.uns      = ls_gnt & bus.ls_unsigned;
        ctx_d.ofs      = req_ofs;
        ctx_d.is_store = ls_gnt & bus.ls_we;
        if (ls_gnt) begin
            ctx_d.owner = OWN_LS;
        end else if (if_gnt) begin
            ctx_d.owner = OWN_IF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctx_q <= CTX_RST;
        end else begin
            ctx_q <= ctx_d;
        end
    end

    // Gating with rst_n drops a response whose grant preceded a reset.
    assign if_vld = rst_n & (ctx_q.owner == OWN_IF);
    assign ls_vld = rst_n & (ctx_q.owner == OWN_LS);

    assign bus.if_rsp_valid = if_vld;
    assign bus.if_rsp_err   = if_vld & ctx_q.err;
    assign bus.if_rsp_data  = (if_vld & ~ctx_q.err) ? bus.mem_rd_data : 32'h0;

    assign bus.ls_rsp_valid = ls_vld;
    assign bus.ls_rsp_err   = ls_vld & ctx_q.err;
    assign bus.ls_rsp_data  = (ls_vld & ~ctx_q.err & ~ctx_q.is_store) ? ld_data : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant-cycle checks inline, responses checked by a queue-driven monitor.
module tb_mem_arbiter;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   vecs = 0;
    int   fails = 0;
    exp_t exp_if[$];
    exp_t exp_ls[$];
    logic [31:0] mem [0:255];

    mem_arbiter_if #(.ADDR_WIDTH(32)) bus ();

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous byte-enabled memory: read data appears the cycle after the address.
    always @(posedge clk) begin
        if (bus.mem_byte_en != 4'b0000) begin
            if (bus.mem_wr_en) begin
                for (int l = 0; l < 4; l++) begin
                    if (bus.mem_byte_en[l]) mem[bus.mem_addr[9:2]][8*l +: 8] <= bus.mem_wr_data[8*l +: 8];
                end
            end else begin
                bus.mem_rd_data <= mem[bus.mem_addr[9:2]];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.if_rsp_valid === 1'b1) begin
            if (exp_if.size() == 0) begin
                chk("if_rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_if.pop_front();
                chk("if_rsp_data", bus.if_rsp_data, e.data);
                chk("if_rsp_err", {31'd0, bus.if_rsp_err}, {31'd0, e.err});
                chk("if_rsp_cycle", cyc, e.cyc);
            end
        end
        if (bus.ls_rsp_valid === 1'b1) begin
            if (exp_ls.size() == 0) begin
                chk("ls_rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_ls.pop_front();
                chk("ls_rsp_data", bus.ls_rsp_data, e.data);
                chk("ls_rsp_err", {31'd0, bus.ls_rsp_err}, {31'd0, e.err});
                chk("ls_rsp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic push_if(input logic [31:0] d, input logic err);
        exp_if.push_back('{data: d, err: err, cyc: cyc + 1});
    endtask

    task automatic push_ls(input logic [31:0] d, input logic err);
        exp_ls.push_back('{data: d, err: err, cyc: cyc + 1});
    endtask

    // Issue one LSU access alone; called just after a posedge, returns just after the grant edge.
    task automatic do_ls(input string tag, input logic [31:0] addr, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] wd, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd, input logic [31:0] exp_data, input logic exp_err,
                         input logic expect_rsp);
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = addr;
        bus.ls_we        = we;
        bus.ls_size      = size;
        bus.ls_unsigned  = uns;
        bus.ls_wdata     = wd;
        @(negedge clk);
        chk({tag, "_ls_ready"}, {31'd0, bus.ls_req_ready}, 32'd1);
        chk({tag, "_if_ready"}, {31'd0, bus.if_req_ready}, 32'd0);
        chk({tag, "_byte_en"}, {28'd0, bus.mem_byte_en}, {28'd0, exp_be});
        chk({tag, "_wr_en"}, {31'd0, bus.mem_wr_en}, {31'd0, we & ~exp_err});
        if (!exp_err) chk({tag, "_mem_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
        if (we && !exp_err) chk({tag, "_wr_data"}, bus.mem_wr_data, exp_wd);
        if (expect_rsp) push_ls(exp_data, exp_err);
        @(posedge clk);
        #1 bus.ls_req_valid = 1'b0;
    endtask

    task automatic do_if(input string tag, input logic [31:0] addr, input logic [31:0] exp_data, input logic exp_err);
        bus.if_req_valid = 1'b1;
        bus.if_addr      = addr;
        @(negedge clk);
        chk({tag, "_if_ready"}, {31'd0, bus.if_req_ready}, 32'd1);
        chk({tag, "_byte_en"}, {28'd0, bus.mem_byte_en}, exp_err ? 32'h0 : 32'hF);
        chk({tag, "_wr_en"}, {31'd0, bus.mem_wr_en}, 32'd0);
        if (!exp_err) chk({tag, "_mem_addr"}, bus.mem_addr, addr);
        push_if(exp_data, exp_err);
        @(posedge clk);
        #1 bus.if_req_valid = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ls_ready"}, {31'd0, bus.ls_req_ready}, 32'd0);
        chk({tag, "_if_ready"}, {31'd0, bus.if_req_ready}, 32'd0);
        chk({tag, "_ls_rsp_valid"}, {31'd0, bus.ls_rsp_valid}, 32'd0);
        chk({tag, "_ls_rsp_data"}, bus.ls_rsp_data, 32'd0);
        chk({tag, "_byte_en"}, {28'd0, bus.mem_byte_en}, 32'd0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        chk({tag, "_wr_en"}, {31'd0, bus.mem_wr_en}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic ls_first;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h41] = 32'hDEADBEEF;
        mem[8'h80] = 32'h1280FF00;
        bus.mem_rd_data  = 32'h0;
        rst_n            = 1'b0;
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 32'h104;
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = 32'h200;
        bus.ls_we        = 1'b0;
        bus.ls_size      = 2'b10;
        bus.ls_unsigned  = 1'b0;
        bus.ls_wdata     = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        chk("reset_if_rsp_valid", {31'd0, bus.if_rsp_valid}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.if_req_valid = 1'b0;
        bus.ls_req_valid = 1'b0;
        @(negedge clk);
        chk_quiet("idle");
        @(posedge clk);
        #1;

        do_if("fetch104", 32'h104, 32'hDEADBEEF, 1'b0);
        do_ls("lb202",  32'h202, 1'b0, 2'b00, 1'b0, 32'h0, 4'b0100, 32'h0, 32'hFFFFFF80, 1'b0, 1'b1);
        do_ls("lbu202", 32'h202, 1'b0, 2'b00, 1'b1, 32'h0, 4'b0100, 32'h0, 32'h00000080, 1'b0, 1'b1);
        do_ls("lhu202", 32'h202, 1'b0, 2'b01, 1'b1, 32'h0, 4'b1100, 32'h0, 32'h00001280, 1'b0, 1'b1);
        do_ls("lh200",  32'h200, 1'b0, 2'b01, 1'b0, 32'h0, 4'b0011, 32'h0, 32'hFFFFFF00, 1'b0, 1'b1);
        do_ls("sb203",  32'h203, 1'b1, 2'b00, 1'b0, 32'h000000A5, 4'b1000, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1);
        do_ls("lw200",  32'h200, 1'b0, 2'b10, 1'b0, 32'h0, 4'b1111, 32'h0, 32'hA580FF00, 1'b0, 1'b1);
        do_ls("sh202",  32'h202, 1'b1, 2'b01, 1'b0, 32'h00001234, 4'b1100, 32'h12341234, 32'h0, 1'b0, 1'b1);
        do_ls("lw102",  32'h102, 1'b0, 2'b10, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b1);
        do_ls("sz11",   32'h100, 1'b1, 2'b11, 1'b0, 32'hFFFFFFFF, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b1);
        do_if("fetch106", 32'h106, 32'h0, 1'b1);

        // Contention: LS word load 0x104 against fetch 0x200 (now 0x1234FF00).
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = 32'h104;
        bus.ls_we        = 1'b0;
        bus.ls_size      = 2'b10;
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 32'h200;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
`ifdef MEM_ARB_RR_EN
            ls_first = (i % 2 == 0);
`else
            ls_first = 1'b1;
`endif
            chk("cont_ls_ready", {31'd0, bus.ls_req_ready}, {31'd0, ls_first});
            chk("cont_if_ready", {31'd0, bus.if_req_ready}, {31'd0, ~ls_first});
            if (ls_first) push_ls(32'hDEADBEEF, 1'b0);
            else push_if(32'h1234FF00, 1'b0);
            @(posedge clk);
            #1;
        end
        bus.ls_req_valid = 1'b0;
`ifndef MEM_ARB_RR_EN
        @(negedge clk);
        chk("cont_if_late_ready", {31'd0, bus.if_req_ready}, 32'd1);
        push_if(32'h1234FF00, 1'b0);
        @(posedge clk);
        #1;
`endif
        bus.if_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset lands in the response cycle of a load: the response must vanish.
        do_ls("lw_rst", 32'h200, 1'b0, 2'b10, 1'b0, 32'h0, 4'b1111, 32'h0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk_quiet("rst_pending");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ls_rsp_valid", {31'd0, bus.ls_rsp_valid}, 32'd0);
        chk("post_rst_if_rsp_valid", {31'd0, bus.if_rsp_valid}, 32'd0);
        @(posedge clk);
        #1;

        // First post-reset traffic is contended; the pointer restarts at IF.
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = 32'h200;
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 32'h104;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
`ifdef MEM_ARB_RR_EN
            ls_first = (i == 1);
`else
            ls_first = (i == 0);
`endif
            chk("post_ls_ready", {31'd0, bus.ls_req_ready}, {31'd0, ls_first});
            chk("post_if_ready", {31'd0, bus.if_req_ready}, {31'd0, ~ls_first});
            if (ls_first) push_ls(32'h1234FF00, 1'b0);
            else push_if(32'hDEADBEEF, 1'b0);
            @(posedge clk);
            #1;
            if (ls_first) bus.ls_req_valid = 1'b0;
            else bus.if_req_valid = 1'b0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pending_if", exp_if.size(), 32'd0);
        chk("pending_ls", exp_ls.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port byte-enabled `memory` between the instruction-fetch unit and the load/store unit. It grants at most one request per cycle and drives the memory port. It converts LSU byte/halfword/word accesses into byte-lane enables and replicated write data, then returns aligned, sign- or zero-extended read data one cycle later. Misaligned or illegal accesses are rejected without touching memory.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte-address width.
- `DATA_WIDTH`, 32, data width. Only 32 is supported; byte_en is 4 bits.

Ports (reset is synchronous, active-low):
- `clk` in 1: sole clock.
- `rst_n` in 1: synchronous active-low reset.
- `if_req_valid` in 1: fetch request.
- `if_req_ready` out 1: fetch granted this cycle.
- `if_addr` in ADDR_WIDTH: fetch byte address.
- `if_rsp_valid` out 1: fetch response.
- `if_rsp_data` out 32: instruction word.
- `if_rsp_err` out 1: misaligned fetch.
- `ls_req_valid` in 1: LSU request.
- `ls_req_ready` out 1: LSU granted this cycle.
- `ls_addr` in ADDR_WIDTH: LSU byte address.
- `ls_we` in 1: 1 = store.
- `ls_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `ls_unsigned` in 1: zero-extend loads.
- `ls_wdata` in 32: store data, right-justified.
- `ls_rsp_valid` out 1: LSU response; for stores this is the completion.
- `ls_rsp_data` out 32: extended load data; 0 for stores and errors.
- `ls_rsp_err` out 1: misaligned or illegal access.
- `mem_addr` out ADDR_WIDTH: word-aligned address, {addr[31:2],2'b00}.
- `mem_wr_en` out 1: memory write strobe.
- `mem_wr_data` out 32: lane-replicated store data.
- `mem_rd_data` in 32: memory read data, valid the cycle after the address.
- `mem_byte_en` out 4: active lanes.

## Operation
- Handshake: a request transfers when valid && ready. The requester holds valid and its payload stable until ready. ready is combinational from the valids and the arbitration state.
- Arbitration, default: fixed priority, LSU before fetch. A lone requester is always granted.
- Each granted request produces exactly one rsp_valid pulse on its own port. There is no response back-pressure.
- Grant cycle, legal LSU access:
  - mem_wr_en = ls_we.
  - mem_byte_en: byte → 0001<<a[1:0]; half → 0011<<a[1:0]; word → 1111.
  - mem_wr_data: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
- Grant cycle, fetch: mem_byte_en = 1111, mem_wr_en = 0.
- Errors (grant still given, memory not driven: wr_en=0, byte_en=0):
  - half with a[0]=1;
  - word with a[1:0]≠0;
  - ls_size=11;
  - fetch with a[1:0]≠0.
  - The response carries err=1 and data=0.
- Registered response context: owner (NONE/IF/LS), err, size, unsigned, a[1:0], is_store.
- Load data select:
  - byte: rd_data[8*a +: 8];
  - half: rd_data[16*a[1] +: 16];
  - then sign- or zero-extend per ls_unsigned.
- Idle: memory outputs all 0; both ready deasserted when no request is pending.

## Timing
- Grant in cycle N; rsp_valid and rsp data/err in cycle N+1, decoded combinationally from mem_rd_data and the registered context.
- Throughput is one grant per cycle. A new grant is allowed in the same cycle as the previous response.
- Simultaneous requests: the loser's ready is 0. It keeps valid and is granted in the next free cycle.
- Reset values: all rsp_valid/err = 0, rsp_data = 0, owner = NONE, ready = 0 while rst_n=0, memory outputs = 0, RR pointer = IF.
- Reset asserted while a response is pending: the response is dropped. No rsp_valid appears in the first cycle after reset deasserts.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit pointer names the preferred requester.
  - After any grant, the pointer moves to the other requester.
  - Under continuous contention the grants alternate LS, IF, LS, …
- Undefined: fixed LSU-first priority, no pointer flop.

## Structure
- `mem_arb_pkg`:
  - size enum SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10;
  - owner enum OWN_NONE/OWN_IF/OWN_LS;
  - lane constants.
- Sub-module `mem_lane_align` (combinational) does:
  - byte_en generation;
  - store-data replication;
  - misalignment check;
  - load extraction and extension.
- The top holds arbitration, the response context registers and the RR pointer.

## Test plan
- Fetch alone at 0x104, memory word 0xDEADBEEF → if_req_ready in cycle N; mem_addr=0x104, byte_en=1111; if_rsp_valid in N+1 with data 0xDEADBEEF.
- SB of wdata 0x000000A5 to 0x203 → mem_addr 0x200, byte_en 1000, wr_data 0xA5A5A5A5, wr_en=1; ls_rsp_valid in N+1 with err=0.
- LB from 0x202, memory word 0x1280FF00 → ls_rsp_data 0xFFFFFF80; the same access with ls_unsigned=1 → 0x00000080. LHU from 0x202 → 0x00001280.
- LW at 0x102 → memory untouched (wr_en=0, byte_en=0); ls_rsp_err=1 and data 0 in N+1. ls_size=11 gives the same result.
- Both valid for 4 cycles:
  - default build: LS granted every cycle, IF stalled;
  - with `MEM_ARB_RR_EN`: grants LS, IF, LS, IF.
  - In both builds each response appears on the correct port one cycle after its grant.
- rst_n low in the cycle after an LW grant → no ls_rsp_valid afterwards, all outputs 0; the first post-reset request completes normally.
